alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller in the EXE stage that sequences the single-cycle ALU.
- Accepts one operation per valid/ready handshake and drives the ALU over one or more cycles.
- Supported operations: plain ALU ops (1 step), 64-bit ADD/SUB (2 chained steps), 32x32 low-word MUL (32 shift-add steps).
- Owns the architectural NZCV status register and returns the result on a valid/ready response channel.

Parameters:
- MUL_STEPS, 32, number of shift-add iterations for MUL (one per multiplier bit).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_op  in  2  0=SINGLE, 1=ADD64, 2=SUB64, 3=MUL
- req_cmd  in  4  ALU command for SINGLE (1 MOV, 9 MVN, 2 ADD, 3 ADC, 4 SUB, 5 SBC, 6 AND, 7 ORR, 8 EOR)
- req_s  in  1  update status register on completion
- req_a_lo, req_a_hi, req_b_lo, req_b_hi  in  32 each  operands (hi halves used only by ADD64/SUB64)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_lo, rsp_hi  out  32 each  result (rsp_hi = 0 for SINGLE/MUL)
- rsp_status  out  4  NZCV of this operation, {N,Z,C,V} in bits [3:0]
- alu_cmd  out  4  to ALU EXE_CMD
- alu_val1, alu_val2  out  32 each  to ALU operands
- alu_carry  out  1  to ALU carry-in
- alu_res  in  32  from ALU result
- alu_status  in  4  from ALU, {N,Z,C,V}
- sr_out  out  4  architectural status register, {N,Z,C,V}

Behaviour:
- Reset (async, any state): state=IDLE; rsp_valid, rsp_lo, rsp_hi, rsp_status, sr_out all 0; alu_cmd=0, alu_val1=0, alu_val2=0, alu_carry=0. A reset mid-operation aborts it with no SR update.
- States: IDLE, EXEC_LO, EXEC_HI, MUL_ITER, DONE.
- ALU outputs are combinational from state and registered operands. alu_cmd=0 in IDLE and DONE.
- IDLE:
  - req_ready=1. On req_valid, latch all req_* fields.
  - SINGLE/ADD64/SUB64 -> EXEC_LO. MUL -> MUL_ITER with acc=0, i=0.
- EXEC_LO:
  - SINGLE: cmd=req_cmd, val1=a_lo, val2=b_lo, carry=sr_out.C. Capture alu_res and alu_status, -> DONE.
  - ADD64: cmd=2, carry=0. Capture lo and an internal carry k=alu_status.C, -> EXEC_HI.
  - SUB64: cmd=4. Capture lo and k = ~(a_lo <u b_lo); the sequencer computes the borrow itself because the ALU reports no carry on subtract. -> EXEC_HI.
- EXEC_HI:
  - ADD64: cmd=3. SUB64: cmd=5. Operands val1=a_hi, val2=b_hi, carry=k.
  - Capture hi. Status: N, C, V from this step's alu_status; Z = Z_lo & Z_hi. -> DONE.
- MUL_ITER:
  - cmd=2, carry=0, val1=acc, val2 = b_lo[i] ? (a_lo << i) : 0.
  - acc <= alu_res; i increments. After step i=MUL_STEPS-1, -> DONE.
  - Status: N, Z from final acc; C, V = current sr_out.C, sr_out.V (preserved).
- DONE:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On entry to DONE, if s=1 then sr_out <= rsp_status (exactly once per op).
  - On rsp_valid & rsp_ready -> IDLE. There is always one IDLE cycle between ops; no back-to-back accept.
- Latency from accept edge to first rsp_valid cycle: SINGLE 2, ADD64/SUB64 3, MUL MUL_STEPS+1 (33).
- Widths: 64-bit results are {hi, lo}; MUL keeps the low 32 bits only, overflow is discarded.
- req_valid while not IDLE is ignored (req_ready=0). req_cmd values outside the listed set go to the ALU unchanged (result 0).

Decomposition:
- Shared package alu_pkg:
  - EXE_CMD localparams (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR).
  - req_op encoding.
  - Status bit indices N=3, Z=2, C=1, V=0.
  - Sequencer state enum.
- One natural sub-module: status_reg, the NZCV register with async reset and a write-enable.

Test Plan:
- SINGLE ADD, S=1, a_lo=FFFFFFFF, b_lo=1 -> rsp_lo=0, rsp_status=4'b0110, sr_out=0110, rsp_valid 2 cycles after accept.
- With sr_out.C=1, SINGLE ADC 5+3, S=0 -> rsp_lo=9, alu_carry=1 during EXEC_LO, sr_out unchanged.
- ADD64 0x00000000_FFFFFFFF + 0x00000000_00000001 -> {rsp_hi,rsp_lo}=0x00000001_00000000, status Z=0, latency 3.
- SUB64 0x00000001_00000000 - 0x00000000_00000001 -> 0x00000000_FFFFFFFF; SBC step sees alu_carry=0.
- MUL 0x00010001 x 3, S=1, sr_out initially 0011 -> rsp_lo=0x00030003, rsp_status=0011 (C/V preserved), latency 33.
- Hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0. Then assert rst mid-MUL -> IDLE, rsp_valid=0, sr_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the EXE-stage ALU and its multi-cycle sequencer.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'd1;
  localparam logic [3:0] CMD_ADD = 4'd2;
  localparam logic [3:0] CMD_ADC = 4'd3;
  localparam logic [3:0] CMD_SUB = 4'd4;
  localparam logic [3:0] CMD_SBC = 4'd5;
  localparam logic [3:0] CMD_AND = 4'd6;
  localparam logic [3:0] CMD_ORR = 4'd7;
  localparam logic [3:0] CMD_EOR = 4'd8;
  localparam logic [3:0] CMD_MVN = 4'd9;

  localparam logic [1:0] OP_SINGLE = 2'd0;
  localparam logic [1:0] OP_ADD64  = 2'd1;
  localparam logic [1:0] OP_SUB64  = 2'd2;
  localparam logic [1:0] OP_MUL    = 2'd3;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC_LO  = 3'd1,
    ST_EXEC_HI  = 3'd2,
    ST_MUL_ITER = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/status_reg.sv
// Architectural NZCV status register with write enable.
module status_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= 4'b0000;
    else if (we)
      q <= d;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle EXE controller: drives a single-cycle ALU for plain ops,
// chained 64-bit ADD/SUB and shift-add 32x32 low-word MUL.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [3:0]  req_cmd,
  input  logic        req_s,
  input  logic [31:0] req_a_lo,
  input  logic [31:0] req_a_hi,
  input  logic [31:0] req_b_lo,
  input  logic [31:0] req_b_hi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic [3:0]  rsp_status,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic        alu_carry,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_status,
  output logic [3:0]  sr_out
);

  localparam int IW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [IW-1:0] LAST_STEP = IW'(MUL_STEPS - 1);

  seq_state_t    state;
  logic [1:0]    op;
  logic [3:0]    cmd;
  logic          s;
  logic [31:0]   a_lo, a_hi, b_lo, b_hi;
  logic          k;
  logic          z_lo;
  logic [IW-1:0] i;

  logic          finishing;
  logic [3:0]    next_status;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  // rsp_lo doubles as the MUL accumulator.
  always_comb begin
    alu_cmd   = 4'd0;
    alu_val1  = 32'd0;
    alu_val2  = 32'd0;
    alu_carry = 1'b0;
    case (state)
      ST_EXEC_LO: begin
        alu_val1 = a_lo;
        alu_val2 = b_lo;
        case (op)
          OP_ADD64: alu_cmd = CMD_ADD;
          OP_SUB64: alu_cmd = CMD_SUB;
          default: begin
            alu_cmd   = cmd;
            alu_carry = sr_out[SR_C];
          end
        endcase
      end
      ST_EXEC_HI: begin
        alu_cmd   = (op == OP_SUB64) ? CMD_SBC : CMD_ADC;
        alu_val1  = a_hi;
        alu_val2  = b_hi;
        alu_carry = k;
      end
      ST_MUL_ITER: begin
        alu_cmd  = CMD_ADD;
        alu_val1 = rsp_lo;
        alu_val2 = b_lo[i] ? (a_lo << i) : 32'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    finishing   = 1'b0;
    next_status = alu_status;
    case (state)
      ST_EXEC_LO:  finishing = (op == OP_SINGLE);
      ST_EXEC_HI: begin
        finishing   = 1'b1;
        next_status = {alu_status[SR_N], z_lo & alu_status[SR_Z],
                       alu_status[SR_C], alu_status[SR_V]};
      end
      ST_MUL_ITER: begin
        finishing   = (i == LAST_STEP);
        next_status = {alu_res[31], (alu_res == 32'd0),
                       sr_out[SR_C], sr_out[SR_V]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op         <= OP_SINGLE;
      cmd        <= 4'd0;
      s          <= 1'b0;
      a_lo       <= 32'd0;
      a_hi       <= 32'd0;
      b_lo       <= 32'd0;
      b_hi       <= 32'd0;
      k          <= 1'b0;
      z_lo       <= 1'b0;
      i          <= '0;
      rsp_lo     <= 32'd0;
      rsp_hi     <= 32'd0;
      rsp_status <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op     <= req_op;
            cmd    <= req_cmd;
            s      <= req_s;
            a_lo   <= req_a_lo;
            a_hi   <= req_a_hi;
            b_lo   <= req_b_lo;
            b_hi   <= req_b_hi;
            i      <= '0;
            rsp_lo <= 32'd0;
            rsp_hi <= 32'd0;
            state  <= (req_op == OP_MUL) ? ST_MUL_ITER : ST_EXEC_LO;
          end
        end
        ST_EXEC_LO: begin
          rsp_lo <= alu_res;
          if (op == OP_SINGLE) begin
            rsp_status <= next_status;
            state      <= ST_DONE;
          end else begin
            // The ALU reports no carry on subtract, so derive the borrow here.
            k     <= (op == OP_ADD64) ? alu_status[SR_C] : ~(a_lo < b_lo);
            z_lo  <= alu_status[SR_Z];
            state <= ST_EXEC_HI;
          end
        end
        ST_EXEC_HI: begin
          rsp_hi     <= alu_res;
          rsp_status <= next_status;
          state      <= ST_DONE;
        end
        ST_MUL_ITER: begin
          rsp_lo <= alu_res;
          i      <= i + 1'b1;
          if (finishing) begin
            rsp_status <= next_status;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  status_reg u_status_reg (
    .clk (clk),
    .rst (rst),
    .we  (finishing & s),
    .d   (next_status),
    .q   (sr_out)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural single-cycle ALU.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_cmd;
  logic        req_s;
  logic [31:0] req_a_lo, req_a_hi, req_b_lo, req_b_hi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic [3:0]  rsp_status;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_val1, alu_val2;
  logic        alu_carry;
  logic [31:0] alu_res;
  logic [3:0]  alu_status;
  logic [3:0]  sr_out;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic carry1, carry2;
  logic [3:0] cmd2;
  logic [31:0] held_lo;

  logic [32:0] m_wide;
  logic        m_c, m_v;

  alu_op_sequencer #(.MUL_STEPS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_cmd    (req_cmd),
    .req_s      (req_s),
    .req_a_lo   (req_a_lo),
    .req_a_hi   (req_a_hi),
    .req_b_lo   (req_b_lo),
    .req_b_hi   (req_b_hi),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lo     (rsp_lo),
    .rsp_hi     (rsp_hi),
    .rsp_status (rsp_status),
    .alu_cmd    (alu_cmd),
    .alu_val1   (alu_val1),
    .alu_val2   (alu_val2),
    .alu_carry  (alu_carry),
    .alu_res    (alu_res),
    .alu_status (alu_status),
    .sr_out     (sr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: subtracts never report carry; unknown commands give 0.
  always_comb begin
    m_wide = 33'd0;
    m_c    = 1'b0;
    m_v    = 1'b0;
    case (alu_cmd)
      4'd1: m_wide = {1'b0, alu_val2};
      4'd9: m_wide = {1'b0, ~alu_val2};
      4'd2, 4'd3: begin
        m_wide = {1'b0, alu_val1} + {1'b0, alu_val2}
               + {32'd0, (alu_cmd == 4'd3) & alu_carry};
        m_c = m_wide[32];
        m_v = (alu_val1[31] == alu_val2[31]) && (m_wide[31] != alu_val1[31]);
      end
      4'd4, 4'd5: begin
        m_wide = {1'b0, alu_val1 - alu_val2
               - {31'd0, (alu_cmd == 4'd5) & ~alu_carry}};
        m_v = (alu_val1[31] != alu_val2[31]) && (m_wide[31] != alu_val1[31]);
      end
      4'd6: m_wide = {1'b0, alu_val1 & alu_val2};
      4'd7: m_wide = {1'b0, alu_val1 | alu_val2};
      4'd8: m_wide = {1'b0, alu_val1 ^ alu_val2};
      default: ;
    endcase
    alu_res    = m_wide[31:0];
    alu_status = {m_wide[31], (m_wide[31:0] == 32'd0), m_c, m_v};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request in IDLE and measures cycles until rsp_valid.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] cmd,
                               input logic s, input logic [63:0] a,
                               input logic [63:0] b);
    req_op    = op;
    req_cmd   = cmd;
    req_s     = s;
    req_a_lo  = a[31:0];
    req_a_hi  = a[63:32];
    req_b_lo  = b[31:0];
    req_b_hi  = b[63:32];
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat    = 1;
    carry1 = alu_carry;
    carry2 = 1'b0;
    cmd2   = 4'd0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) begin
        carry2 = alu_carry;
        cmd2   = alu_cmd;
      end
    end
  endtask

  task automatic finishResponse();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("back_to_idle", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op = 2'd0; req_cmd = 4'd0; req_s = 1'b0;
    req_a_lo = '0; req_a_hi = '0; req_b_lo = '0; req_b_hi = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset_sr", {60'd0, sr_out}, 64'd0);
    checkOutput("reset_alu_cmd", {60'd0, alu_cmd}, 64'd0);
    checkOutput("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);

    $display("[TB] SINGLE ADD with carry-out");
    applyStimulus(2'd0, 4'd2, 1'b1, 64'hFFFF_FFFF, 64'h1);
    checkOutput("add_latency", 64'(lat), 64'd2);
    checkOutput("add_rsp_lo", {32'd0, rsp_lo}, 64'd0);
    checkOutput("add_rsp_hi", {32'd0, rsp_hi}, 64'd0);
    checkOutput("add_status", {60'd0, rsp_status}, 64'h6);
    checkOutput("add_sr", {60'd0, sr_out}, 64'h6);
    checkOutput("add_req_ready_done", {63'd0, req_ready}, 64'd0);
    finishResponse();

    $display("[TB] SINGLE ADC using SR carry, no SR update");
    applyStimulus(2'd0, 4'd3, 1'b0, 64'd5, 64'd3);
    checkOutput("adc_carry_in", {63'd0, carry1}, 64'd1);
    checkOutput("adc_rsp_lo", {32'd0, rsp_lo}, 64'd9);
    checkOutput("adc_sr_kept", {60'd0, sr_out}, 64'h6);
    finishResponse();

    $display("[TB] ADD64 carry into high word");
    applyStimulus(2'd1, 4'd0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1);
    checkOutput("add64_latency", 64'(lat), 64'd3);
    checkOutput("add64_result", {rsp_hi, rsp_lo}, 64'h0000_0001_0000_0000);
    checkOutput("add64_status", {60'd0, rsp_status}, 64'h0);
    checkOutput("add64_hi_cmd", {60'd0, cmd2}, 64'd3);
    finishResponse();

    $display("[TB] SUB64 borrow from high word");
    applyStimulus(2'd2, 4'd0, 1'b0, 64'h0000_0001_0000_0000, 64'h1);
    checkOutput("sub64_latency", 64'(lat), 64'd3);
    checkOutput("sub64_result", {rsp_hi, rsp_lo}, 64'h0000_0000_FFFF_FFFF);
    checkOutput("sub64_sbc_carry", {63'd0, carry2}, 64'd0);
    checkOutput("sub64_hi_cmd", {60'd0, cmd2}, 64'd5);
    checkOutput("sub64_status", {60'd0, rsp_status}, 64'h0);
    finishResponse();

    $display("[TB] SINGLE ADD setting C and V");
    applyStimulus(2'd0, 4'd2, 1'b1, 64'h8000_0000, 64'h8000_0001);
    checkOutput("addcv_rsp_lo", {32'd0, rsp_lo}, 64'd1);
    checkOutput("addcv_sr", {60'd0, sr_out}, 64'h3);
    finishResponse();

    $display("[TB] MUL preserving C and V");
    applyStimulus(2'd3, 4'd0, 1'b1, 64'h0001_0001, 64'd3);
    checkOutput("mul_latency", 64'(lat), 64'd33);
    checkOutput("mul_rsp_lo", {32'd0, rsp_lo}, 64'h0003_0003);
    checkOutput("mul_rsp_hi", {32'd0, rsp_hi}, 64'd0);
    checkOutput("mul_status", {60'd0, rsp_status}, 64'h3);
    checkOutput("mul_sr", {60'd0, sr_out}, 64'h3);
    finishResponse();

    $display("[TB] Backpressure with request held");
    applyStimulus(2'd0, 4'd8, 1'b0, 64'hF0F0_F0F0, 64'hFF00_FF00);
    checkOutput("eor_rsp_lo", {32'd0, rsp_lo}, 64'h0FF0_0FF0);
    held_lo = rsp_lo;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("hold_rsp_lo", {32'd0, rsp_lo}, {32'd0, held_lo});
      checkOutput("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    checkOutput("eor_sr_kept", {60'd0, sr_out}, 64'h3);
    finishResponse();

    $display("[TB] Reset during MUL");
    req_op = 2'd3; req_s = 1'b1; req_a_lo = 32'd7; req_b_lo = 32'hFFFF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("mid_mul_busy", {63'd0, req_ready}, 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("abort_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("abort_sr", {60'd0, sr_out}, 64'h0);
    checkOutput("abort_alu_cmd", {60'd0, alu_cmd}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle", {63'd0, req_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
